commit_rob: RTL and testbench
=============================

COMMIT_ROB -- requirements
Module: commit_rob

Interface
REQ-001 SHALL have parameter NR_ENTRIES, default 8, meaning ROB depth; SHALL equal 2**TRANS_ID_BITS.
REQ-002 SHALL have parameter NR_COMMIT_PORTS, default 2, meaning head entries presented to commit; only value 2 supported.
REQ-003 SHALL have port clk_i, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, meaning asynchronous active-high reset.
REQ-005 SHALL have port flush_i, input, 1, meaning discard all entries.
REQ-006 SHALL have port issue_valid_i, input, 1, meaning the issue side offers an entry.
REQ-007 SHALL have port issue_instr_i, input, scoreboard_entry_t, meaning the decoded entry to allocate.
REQ-008 SHALL have port issue_ready_o, output, 1, meaning a slot is free.
REQ-009 SHALL have port issue_trans_id_o, output, TRANS_ID_BITS, meaning the index allocated on a handshake, equal to the tail pointer.
REQ-010 SHALL have port wb_valid_i, input, 1, meaning writeback strobe.
REQ-011 SHALL have port wb_trans_id_i, input, TRANS_ID_BITS, meaning the entry to complete.
REQ-012 SHALL have port wb_result_i, input, 64, meaning the result data.
REQ-013 SHALL have port wb_ex_i, input, exception_t, meaning the exception raised by the functional unit.
REQ-014 SHALL have port commit_instr_o, output, scoreboard_entry_t [NR_COMMIT_PORTS-1:0], meaning head and head+1 entries.
REQ-015 SHALL have port commit_ack_i, input, NR_COMMIT_PORTS, meaning the commit stage retires those entries.
REQ-016 SHALL have port count_o, output, TRANS_ID_BITS+1, meaning the number of occupied entries.

Function
REQ-017 SHALL store entries in a circular buffer with head, tail and count registers; pointers wrap modulo NR_ENTRIES.
REQ-018 SHALL drive issue_ready_o = (count < NR_ENTRIES) from registered count only; a same-cycle commit SHALL NOT raise it.
REQ-019 On an issue handshake (issue_valid_i && issue_ready_o), SHALL write issue_instr_i into the tail slot with trans_id = tail, clear its done flag, mark it occupied, and increment tail.
REQ-020 On wb_valid_i to an occupied slot, SHALL write wb_result_i into result and wb_ex_i into ex, and set done; writeback to an unoccupied slot SHALL be ignored.
REQ-021 Writeback to the slot being issued in the same cycle cannot happen legally; on such a collision the issue write SHALL win.
REQ-022 SHALL drive commit_instr_o[k] combinationally from slot head+k, with .valid = occupied && done; all other fields pass through unchanged.
REQ-023 Latency: writeback in cycle N SHALL make the entry visible as valid on commit_instr_o in cycle N+1; issue-to-visible latency SHALL be at least 2 cycles.
REQ-024 commit_ack_i[0] SHALL retire the head slot; commit_ack_i[1] SHALL be honoured only together with commit_ack_i[0]; an ack on an invalid port SHALL be ignored.
REQ-025 Retiring SHALL clear occupied and done for each retired slot and advance head by the number retired (0, 1 or 2).
REQ-026 count SHALL update as count + issued - retired, which covers simultaneous issue and retire; count SHALL never exceed NR_ENTRIES or underflow.
REQ-027 When full, issue_valid_i SHALL be ignored; a retire in the same cycle SHALL free the slot for the next cycle only.
REQ-028 flush_i SHALL take precedence over issue, writeback and retire in the same cycle: it clears all occupied/done flags and sets head=tail=count=0 on the next edge.

Reset
REQ-029 While rst_i is high, the block SHALL immediately clear head, tail, count and all occupied/done flags, independent of clk_i.
REQ-030 Output reset values SHALL be: issue_ready_o=1, issue_trans_id_o=0, count_o=0, commit_instr_o[*].valid=0.
REQ-031 A reset mid-operation SHALL drop all in-flight entries; no ack-driven retire SHALL take effect while rst_i is high.

Verification
REQ-032 Scenario: issue 3 entries, writeback ids 0 and 1 -> next cycle commit_instr_o[0].valid=1 and [1].valid=1, pc values in issue order; ack=2'b11 -> count_o=1, head=2.
REQ-033 Scenario: fill 8 entries -> issue_ready_o=0, count_o=8; a 9th issue_valid_i is ignored; a single ack with an issue in the same cycle -> count_o stays 8 and issue_ready_o=0 in that cycle.
REQ-034 Scenario: out-of-order writeback (id 1 before id 0) -> commit_instr_o[0].valid=0 until id 0 is written back; ack=2'b10 -> no retire.
REQ-035 Scenario: wrap-around, 20 issue/writeback/retire cycles of depth 3 -> trans_id sequence 0..7,0..; results commit in order without loss.
REQ-036 Scenario: flush_i asserted with issue, writeback and ack in the same cycle -> next cycle count_o=0, issue_trans_id_o=0, all commit valids 0.
REQ-037 Scenario: rst_i pulsed asynchronously between clock edges with 5 entries occupied -> outputs take their reset values before the next edge.

Source files
------------

// File: rtl/commit_rob.sv
// rtl/commit_rob.sv - circular reorder buffer feeding a two-wide in-order commit stage
// Entries are allocated at the tail, completed by writeback, and retired from the head.

package commit_rob_pkg;
   localparam int TRANS_ID_BITS = 3;

   typedef struct packed {
      logic        valid;
      logic [5:0]  cause;
      logic [63:0] tval;
   } exception_t;

   typedef struct packed {
      logic [63:0]              pc;
      logic [TRANS_ID_BITS-1:0] trans_id;
      logic [3:0]               fu;
      logic [7:0]               op;
      logic [4:0]               rd;
      logic [63:0]              result;
      logic                     valid;
      exception_t               ex;
   } scoreboard_entry_t;
endpackage

module commit_rob
   import commit_rob_pkg::*;
#(
   parameter int NR_ENTRIES      = 8,
   parameter int NR_COMMIT_PORTS = 2
) (
   input  logic                                    clk_i,
   input  logic                                    rst_i,
   input  logic                                    flush_i,
   input  logic                                    issue_valid_i,
   input  scoreboard_entry_t                       issue_instr_i,
   output logic                                    issue_ready_o,
   output logic [TRANS_ID_BITS-1:0]                issue_trans_id_o,
   input  logic                                    wb_valid_i,
   input  logic [TRANS_ID_BITS-1:0]                wb_trans_id_i,
   input  logic [63:0]                             wb_result_i,
   input  exception_t                              wb_ex_i,
   output scoreboard_entry_t [NR_COMMIT_PORTS-1:0] commit_instr_o,
   input  logic [NR_COMMIT_PORTS-1:0]              commit_ack_i,
   output logic [TRANS_ID_BITS:0]                  count_o
);
   localparam int          TB      = TRANS_ID_BITS;
   localparam logic [TB:0] L_DEPTH = (TB+1)'(NR_ENTRIES);

   scoreboard_entry_t     r_mem [NR_ENTRIES];
   logic [NR_ENTRIES-1:0] r_occ;
   logic [NR_ENTRIES-1:0] r_done;
   logic [TB-1:0]         r_head;
   logic [TB-1:0]         r_tail;
   logic [TB:0]           r_count;

   logic                  w_issue;
   logic                  w_wb_hit;
   logic                  w_ret0;
   logic                  w_ret1;
   logic [TB-1:0]         w_head1;
   logic [TB-1:0]         w_head_nxt;
   logic [TB-1:0]         w_tail_nxt;
   logic [TB:0]           w_count_nxt;
   scoreboard_entry_t     w_issue_entry;
   scoreboard_entry_t     w_commit0;
   scoreboard_entry_t     w_commit1;

   // Ready looks only at the registered count, so a retire this cycle frees a slot next cycle.
   assign issue_ready_o    = (r_count < L_DEPTH);
   assign issue_trans_id_o = r_tail;
   assign count_o          = r_count;

   assign w_issue  = issue_valid_i && issue_ready_o;
   assign w_wb_hit = wb_valid_i && r_occ[wb_trans_id_i];
   assign w_head1  = r_head + TB'(1);

   always_comb begin
      w_commit0       = r_mem[r_head];
      w_commit0.valid = r_occ[r_head] && r_done[r_head];
      w_commit1       = r_mem[w_head1];
      w_commit1.valid = r_occ[w_head1] && r_done[w_head1];
   end

   assign commit_instr_o[0] = w_commit0;
   assign commit_instr_o[1] = w_commit1;

   // The second port only retires behind the first, keeping retirement strictly in order.
   assign w_ret0 = commit_ack_i[0] && w_commit0.valid;
   assign w_ret1 = w_ret0 && commit_ack_i[1] && w_commit1.valid;

   always_comb begin
      w_issue_entry          = issue_instr_i;
      w_issue_entry.trans_id = r_tail;
      w_issue_entry.valid    = 1'b0;

      w_head_nxt = r_head;
      if (w_ret1) begin
         w_head_nxt = r_head + TB'(2);
      end else if (w_ret0) begin
         w_head_nxt = w_head1;
      end

      w_tail_nxt = r_tail;
      if (w_issue) begin
         w_tail_nxt = r_tail + TB'(1);
      end

      w_count_nxt = r_count;
      if (w_issue) begin
         w_count_nxt = w_count_nxt + (TB+1)'(1);
      end
      if (w_ret0) begin
         w_count_nxt = w_count_nxt - (TB+1)'(1);
      end
      if (w_ret1) begin
         w_count_nxt = w_count_nxt - (TB+1)'(1);
      end
   end

   // Later assignments win: retire clears a slot after writeback, issue overrides both.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_occ   <= '0;
         r_done  <= '0;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (flush_i) begin
         r_occ   <= '0;
         r_done  <= '0;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_wb_hit) begin
            r_done[wb_trans_id_i] <= 1'b1;
         end
         if (w_ret0) begin
            r_occ[r_head]  <= 1'b0;
            r_done[r_head] <= 1'b0;
         end
         if (w_ret1) begin
            r_occ[w_head1]  <= 1'b0;
            r_done[w_head1] <= 1'b0;
         end
         if (w_issue) begin
            r_occ[r_tail]  <= 1'b1;
            r_done[r_tail] <= 1'b0;
         end
         r_head  <= w_head_nxt;
         r_tail  <= w_tail_nxt;
         r_count <= w_count_nxt;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!flush_i && !rst_i) begin
         if (w_wb_hit) begin
            r_mem[wb_trans_id_i].result <= wb_result_i;
            r_mem[wb_trans_id_i].ex     <= wb_ex_i;
         end
         if (w_issue) begin
            r_mem[r_tail] <= w_issue_entry;
         end
      end
   end

endmodule

// File: tb/tb_commit_rob.sv
// tb/tb_commit_rob.sv - directed self-checking bench for commit_rob
// Inputs change 1ns after the rising edge; outputs are checked in that same window.

module tb_commit_rob;
   import commit_rob_pkg::*;

   logic                    clk_i;
   logic                    rst_i;
   logic                    flush_i;
   logic                    issue_valid_i;
   scoreboard_entry_t       issue_instr_i;
   logic                    issue_ready_o;
   logic [2:0]              issue_trans_id_o;
   logic                    wb_valid_i;
   logic [2:0]              wb_trans_id_i;
   logic [63:0]             wb_result_i;
   exception_t              wb_ex_i;
   scoreboard_entry_t [1:0] commit_instr_o;
   logic [1:0]              commit_ack_i;
   logic [3:0]              count_o;

   int total;
   int bad;

   commit_rob #(.NR_ENTRIES(8), .NR_COMMIT_PORTS(2)) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .flush_i          (flush_i),
      .issue_valid_i    (issue_valid_i),
      .issue_instr_i    (issue_instr_i),
      .issue_ready_o    (issue_ready_o),
      .issue_trans_id_o (issue_trans_id_o),
      .wb_valid_i       (wb_valid_i),
      .wb_trans_id_i    (wb_trans_id_i),
      .wb_result_i      (wb_result_i),
      .wb_ex_i          (wb_ex_i),
      .commit_instr_o   (commit_instr_o),
      .commit_ack_i     (commit_ack_i),
      .count_o          (count_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clear_inputs();
      flush_i       = 1'b0;
      issue_valid_i = 1'b0;
      issue_instr_i = '0;
      wb_valid_i    = 1'b0;
      wb_trans_id_i = '0;
      wb_result_i   = '0;
      wb_ex_i       = '0;
      commit_ack_i  = '0;
   endtask

   task automatic set_issue(input logic [63:0] pc);
      issue_valid_i    = 1'b1;
      issue_instr_i    = '0;
      issue_instr_i.pc = pc;
      issue_instr_i.rd = pc[4:0];
   endtask

   task automatic set_wb(input logic [2:0] id, input logic [63:0] res);
      wb_valid_i    = 1'b1;
      wb_trans_id_i = id;
      wb_result_i   = res;
   endtask

   task automatic do_issue(input logic [63:0] pc);
      set_issue(pc);
      tick();
      clear_inputs();
   endtask

   task automatic do_wb(input logic [2:0] id, input logic [63:0] res);
      set_wb(id, res);
      tick();
      clear_inputs();
   endtask

   task automatic do_ack(input logic [1:0] a);
      commit_ack_i = a;
      tick();
      clear_inputs();
   endtask

   task automatic apply_reset();
      clear_inputs();
      rst_i = 1'b1;
      #2;
      rst_i = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      apply_reset();
      total++; if (issue_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", issue_ready_o); end
      total++; if (issue_trans_id_o !== 3'd0) begin bad++; $display("FAIL reset_trans_id got=%0d exp=0", issue_trans_id_o); end
      total++; if (count_o !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count_o); end
      total++; if (commit_instr_o[0].valid !== 1'b0 || commit_instr_o[1].valid !== 1'b0) begin bad++; $display("FAIL reset_valids got=%0b%0b exp=00", commit_instr_o[1].valid, commit_instr_o[0].valid); end
   endtask

   task automatic test_basic();
      apply_reset();
      do_issue(64'h100);
      do_issue(64'h104);
      do_issue(64'h108);
      total++; if (count_o !== 4'd3) begin bad++; $display("FAIL basic_count3 got=%0d exp=3", count_o); end
      total++; if (issue_trans_id_o !== 3'd3) begin bad++; $display("FAIL basic_tail got=%0d exp=3", issue_trans_id_o); end
      total++; if (commit_instr_o[0].valid !== 1'b0) begin bad++; $display("FAIL basic_not_done got=%0b exp=0", commit_instr_o[0].valid); end
      set_wb(3'd0, 64'hA0);
      total++; if (commit_instr_o[0].valid !== 1'b0) begin bad++; $display("FAIL basic_wb_same_cycle got=%0b exp=0", commit_instr_o[0].valid); end
      tick();
      clear_inputs();
      total++; if (commit_instr_o[0].valid !== 1'b1 || commit_instr_o[1].valid !== 1'b0) begin bad++; $display("FAIL basic_wb0_visible got=%0b%0b exp=01", commit_instr_o[1].valid, commit_instr_o[0].valid); end
      total++; if (commit_instr_o[0].result !== 64'hA0) begin bad++; $display("FAIL basic_result0 got=%0h exp=a0", commit_instr_o[0].result); end
      do_wb(3'd1, 64'hB0);
      total++; if (commit_instr_o[1].valid !== 1'b1) begin bad++; $display("FAIL basic_wb1_visible got=%0b exp=1", commit_instr_o[1].valid); end
      total++; if (commit_instr_o[0].pc !== 64'h100 || commit_instr_o[1].pc !== 64'h104) begin bad++; $display("FAIL basic_pc_order got=%0h,%0h exp=100,104", commit_instr_o[0].pc, commit_instr_o[1].pc); end
      total++; if (commit_instr_o[1].trans_id !== 3'd1 || commit_instr_o[1].result !== 64'hB0) begin bad++; $display("FAIL basic_fields1 got=id%0d res%0h exp=id1 resb0", commit_instr_o[1].trans_id, commit_instr_o[1].result); end
      do_ack(2'b11);
      total++; if (count_o !== 4'd1) begin bad++; $display("FAIL basic_count_after_ack got=%0d exp=1", count_o); end
      total++; if (commit_instr_o[0].trans_id !== 3'd2 || commit_instr_o[0].pc !== 64'h108) begin bad++; $display("FAIL basic_head2 got=id%0d pc%0h exp=id2 pc108", commit_instr_o[0].trans_id, commit_instr_o[0].pc); end
      total++; if (commit_instr_o[0].valid !== 1'b0) begin bad++; $display("FAIL basic_head2_valid got=%0b exp=0", commit_instr_o[0].valid); end
   endtask

   task automatic test_full();
      apply_reset();
      for (int i = 0; i < 8; i++) begin
         set_issue(64'h200 + 64'(4 * i));
         tick();
      end
      set_issue(64'h999);
      total++; if (issue_ready_o !== 1'b0 || count_o !== 4'd8) begin bad++; $display("FAIL full_state got=ready%0b cnt%0d exp=ready0 cnt8", issue_ready_o, count_o); end
      tick();
      clear_inputs();
      total++; if (count_o !== 4'd8 || issue_trans_id_o !== 3'd0) begin bad++; $display("FAIL full_ninth_ignored got=cnt%0d tail%0d exp=cnt8 tail0", count_o, issue_trans_id_o); end
      total++; if (commit_instr_o[0].pc !== 64'h200) begin bad++; $display("FAIL full_head_intact got=%0h exp=200", commit_instr_o[0].pc); end
      do_wb(3'd0, 64'h55);
      commit_ack_i = 2'b01;
      set_issue(64'h300);
      total++; if (count_o !== 4'd8 || issue_ready_o !== 1'b0) begin bad++; $display("FAIL full_ack_same_cycle got=cnt%0d ready%0b exp=cnt8 ready0", count_o, issue_ready_o); end
      tick();
      clear_inputs();
      total++; if (count_o !== 4'd7 || issue_ready_o !== 1'b1) begin bad++; $display("FAIL full_after_retire got=cnt%0d ready%0b exp=cnt7 ready1", count_o, issue_ready_o); end
      total++; if (commit_instr_o[0].pc !== 64'h204) begin bad++; $display("FAIL full_head_advanced got=%0h exp=204", commit_instr_o[0].pc); end
      set_issue(64'h300);
      total++; if (issue_trans_id_o !== 3'd0) begin bad++; $display("FAIL full_wrap_id got=%0d exp=0", issue_trans_id_o); end
      tick();
      clear_inputs();
      total++; if (count_o !== 4'd8 || issue_ready_o !== 1'b0) begin bad++; $display("FAIL full_refill got=cnt%0d ready%0b exp=cnt8 ready0", count_o, issue_ready_o); end
   endtask

   task automatic test_ooo();
      apply_reset();
      do_issue(64'h400);
      do_issue(64'h404);
      do_wb(3'd1, 64'h11);
      total++; if (commit_instr_o[0].valid !== 1'b0 || commit_instr_o[1].valid !== 1'b1) begin bad++; $display("FAIL ooo_valids got=%0b%0b exp=10", commit_instr_o[1].valid, commit_instr_o[0].valid); end
      do_ack(2'b10);
      total++; if (count_o !== 4'd2) begin bad++; $display("FAIL ooo_ack10 got=%0d exp=2", count_o); end
      do_ack(2'b11);
      total++; if (count_o !== 4'd2) begin bad++; $display("FAIL ooo_ack11_blocked got=%0d exp=2", count_o); end
      do_wb(3'd0, 64'h10);
      total++; if (commit_instr_o[0].valid !== 1'b1 || commit_instr_o[0].result !== 64'h10) begin bad++; $display("FAIL ooo_head_done got=%0b res%0h exp=1 res10", commit_instr_o[0].valid, commit_instr_o[0].result); end
      do_ack(2'b11);
      total++; if (count_o !== 4'd0 || issue_trans_id_o !== 3'd2) begin bad++; $display("FAIL ooo_drain got=cnt%0d tail%0d exp=cnt0 tail2", count_o, issue_trans_id_o); end
   endtask

   task automatic test_wrap();
      apply_reset();
      for (int i = 0; i < 23; i++) begin
         clear_inputs();
         if (i < 20) begin
            set_issue(64'h1000 + 64'(i));
            total++; if (issue_trans_id_o !== 3'(i % 8)) begin bad++; $display("FAIL wrap_issue_id[%0d] got=%0d exp=%0d", i, issue_trans_id_o, i % 8); end
         end
         if (i >= 2 && i <= 21) begin
            set_wb(3'((i - 2) % 8), 64'hCAFE_0000 + 64'(i - 2));
         end
         if (i >= 3) begin
            total++;
            if (commit_instr_o[0].valid !== 1'b1 || commit_instr_o[0].pc !== 64'h1000 + 64'(i - 3) ||
                commit_instr_o[0].result !== 64'hCAFE_0000 + 64'(i - 3) || commit_instr_o[0].trans_id !== 3'((i - 3) % 8)) begin
               bad++;
               $display("FAIL wrap_commit[%0d] got=v%0b pc%0h res%0h id%0d exp=v1 pc%0h res%0h id%0d", i,
                        commit_instr_o[0].valid, commit_instr_o[0].pc, commit_instr_o[0].result, commit_instr_o[0].trans_id,
                        64'h1000 + 64'(i - 3), 64'hCAFE_0000 + 64'(i - 3), (i - 3) % 8);
            end
            commit_ack_i = 2'b01;
         end
         if (i >= 3 && i < 20) begin
            total++; if (count_o !== 4'd3) begin bad++; $display("FAIL wrap_depth[%0d] got=%0d exp=3", i, count_o); end
         end
         tick();
      end
      clear_inputs();
      total++; if (count_o !== 4'd0 || issue_trans_id_o !== 3'd4) begin bad++; $display("FAIL wrap_drained got=cnt%0d tail%0d exp=cnt0 tail4", count_o, issue_trans_id_o); end
   endtask

   task automatic test_flush();
      apply_reset();
      do_issue(64'h500);
      do_issue(64'h504);
      do_issue(64'h508);
      do_wb(3'd0, 64'h77);
      flush_i = 1'b1;
      set_issue(64'h50C);
      set_wb(3'd1, 64'h88);
      commit_ack_i = 2'b01;
      tick();
      clear_inputs();
      total++; if (count_o !== 4'd0 || issue_trans_id_o !== 3'd0 || issue_ready_o !== 1'b1) begin bad++; $display("FAIL flush_state got=cnt%0d tail%0d ready%0b exp=cnt0 tail0 ready1", count_o, issue_trans_id_o, issue_ready_o); end
      total++; if (commit_instr_o[0].valid !== 1'b0 || commit_instr_o[1].valid !== 1'b0) begin bad++; $display("FAIL flush_valids got=%0b%0b exp=00", commit_instr_o[1].valid, commit_instr_o[0].valid); end
      do_issue(64'h600);
      total++; if (commit_instr_o[0].pc !== 64'h600 || commit_instr_o[0].trans_id !== 3'd0 || commit_instr_o[0].valid !== 1'b0) begin bad++; $display("FAIL flush_restart got=pc%0h id%0d v%0b exp=pc600 id0 v0", commit_instr_o[0].pc, commit_instr_o[0].trans_id, commit_instr_o[0].valid); end
   endtask

   task automatic test_async_reset();
      apply_reset();
      for (int i = 0; i < 5; i++) begin
         do_issue(64'h700 + 64'(4 * i));
      end
      do_wb(3'd0, 64'h1);
      total++; if (count_o !== 4'd5 || commit_instr_o[0].valid !== 1'b1) begin bad++; $display("FAIL async_pre got=cnt%0d v%0b exp=cnt5 v1", count_o, commit_instr_o[0].valid); end
      #2;
      commit_ack_i = 2'b01;
      rst_i = 1'b1;
      #1;
      total++; if (count_o !== 4'd0 || issue_ready_o !== 1'b1 || issue_trans_id_o !== 3'd0) begin bad++; $display("FAIL async_mid_cycle got=cnt%0d ready%0b tail%0d exp=cnt0 ready1 tail0", count_o, issue_ready_o, issue_trans_id_o); end
      total++; if (commit_instr_o[0].valid !== 1'b0 || commit_instr_o[1].valid !== 1'b0) begin bad++; $display("FAIL async_valids got=%0b%0b exp=00", commit_instr_o[1].valid, commit_instr_o[0].valid); end
      tick();
      total++; if (count_o !== 4'd0) begin bad++; $display("FAIL async_held got=%0d exp=0", count_o); end
      rst_i = 1'b0;
      clear_inputs();
      do_issue(64'h800);
      total++; if (count_o !== 4'd1 || commit_instr_o[0].pc !== 64'h800) begin bad++; $display("FAIL async_recover got=cnt%0d pc%0h exp=cnt1 pc800", count_o, commit_instr_o[0].pc); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_i = 1'b1;
      clear_inputs();
      test_reset();
      test_basic();
      test_full();
      test_ooo();
      test_wrap();
      test_flush();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
